// File: rtl/chess_move_pkg.sv
// Shared constants for the move collector: move field layout,
// word geometry and collector FSM encoding.
package chess_move_pkg;

    localparam int NCOLS  = 8;
    localparam int MOVE_W = 19;
    localparam int SLOTS  = 8;
    localparam int CNT_W  = 8;
    localparam int WORD_W = SLOTS * MOVE_W;

    localparam int INV    = 18;
    localparam int PROMO  = 17;
    localparam int PAWN   = 16;
    localparam int PAWN2  = 15;
    localparam int EP     = 14;
    localparam int CASTLE = 13;
    localparam int CAPT   = 12;

    localparam int FROM_HI = 11;
    localparam int FROM_LO = 6;
    localparam int TO_HI   = 5;
    localparam int TO_LO   = 0;

    typedef enum logic [2:0] {
        ST_SCAN,
        ST_WAIT,
        ST_CAPT,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/move_unpacker.sv
// Holds one column word and streams its valid move slots, lowest
// slot first, on a valid/ready port; invalid slots cost no cycles.
module move_unpacker
    import chess_move_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word_in,
    output logic [MOVE_W-1:0] move_out,
    output logic              move_valid,
    input  logic              move_ready,
    output logic              word_empty,
    output logic              move_last
);

    logic [WORD_W-1:0] word_q;
    logic [3:0]        slot_ptr;
    logic              found;
    logic              more;
    logic [2:0]        sel_idx;

    // slot_ptr == SLOTS marks the word as fully consumed
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q   <= '0;
            slot_ptr <= 4'(SLOTS);
        end else if (load) begin
            word_q   <= word_in;
            slot_ptr <= 4'd0;
        end else if (move_valid && move_ready) begin
            slot_ptr <= {1'b0, sel_idx} + 4'd1;
        end
    end

    always_comb begin
        found   = 1'b0;
        more    = 1'b0;
        sel_idx = 3'd0;
        for (int k = 0; k < SLOTS; k++) begin
            if (!word_q[k*MOVE_W+INV] && (4'(k) >= slot_ptr)) begin
                if (!found) begin
                    found   = 1'b1;
                    sel_idx = 3'(k);
                end else begin
                    more = 1'b1;
                end
            end
        end
    end

    assign move_out   = found ? word_q[sel_idx*MOVE_W +: MOVE_W] : '0;
    assign move_valid = found;
    assign word_empty = !found;
    assign move_last  = !more;

endmodule

// File: rtl/board_move_collector.sv
// Round-robin drains the column move FIFOs into a single move stream.
// Optional CAPTURE_COUNT_EN adds a saturating capture-move counter.
module board_move_collector
    import chess_move_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCOLS*WORD_W-1:0] col_fifo_out,
    input  logic [NCOLS-1:0]        col_fifo_empty,
    input  logic [NCOLS-1:0]        col_done,
    output logic [NCOLS-1:0]        col_rden,
    output logic [MOVE_W-1:0]       move_out,
    output logic                    move_valid,
    input  logic                    move_ready,
    output logic [CNT_W-1:0]        move_count,
`ifdef CAPTURE_COUNT_EN
    output logic [CNT_W-1:0]        capture_count,
`endif
    output logic                    done
);

    state_t     state;
    state_t     state_nx;
    logic [2:0] rr_ptr;
    logic [2:0] cur_col;
    logic [2:0] scan_col;
    logic [2:0] idx;
    logic       scan_hit;
    logic       word_empty;
    logic       move_last;
    logic       accept;
    logic       emit_end;

    assign accept   = move_valid && move_ready;
    assign emit_end = word_empty || (accept && move_last);

    always_comb begin
        scan_hit = 1'b0;
        scan_col = 3'd0;
        idx      = 3'd0;
        for (int i = 0; i < NCOLS; i++) begin
            idx = rr_ptr + 3'(i);
            if (!scan_hit && !col_fifo_empty[idx]) begin
                scan_hit = 1'b1;
                scan_col = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_SCAN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_SCAN: begin
                if (scan_hit) begin
                    state_nx = ST_WAIT;
                end else if (&col_done) begin
                    state_nx = ST_DONE;
                end
            end
            ST_WAIT: state_nx = ST_CAPT;
            ST_CAPT: state_nx = ST_EMIT;
            ST_EMIT: begin
                if (emit_end) begin
                    state_nx = ST_SCAN;
                end
            end
            ST_DONE: state_nx = ST_DONE;
            default: state_nx = ST_SCAN;
        endcase
    end

    always_comb begin
        col_rden = '0;
        if (reset && state == ST_SCAN && scan_hit) begin
            col_rden[scan_col] = 1'b1;
        end
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr     <= 3'd0;
            cur_col    <= 3'd0;
            move_count <= '0;
        end else begin
            if (state == ST_SCAN && scan_hit) begin
                cur_col <= scan_col;
            end
            if (state == ST_EMIT && emit_end) begin
                rr_ptr <= cur_col + 3'd1;
            end
            if (accept && move_count != '1) begin
                move_count <= move_count + 1'b1;
            end
        end
    end

`ifdef CAPTURE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            capture_count <= '0;
        end else if (accept && move_out[CAPT] && capture_count != '1) begin
            capture_count <= capture_count + 1'b1;
        end
    end
`endif

    move_unpacker u_unpack (
        .clk        (clk),
        .reset      (reset),
        .load       (state == ST_CAPT),
        .word_in    (col_fifo_out[cur_col*WORD_W +: WORD_W]),
        .move_out   (move_out),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .word_empty (word_empty),
        .move_last  (move_last)
    );

endmodule

// File: tb/tb_board_move_collector.sv
// Directed bench for board_move_collector with a behavioural
// non-show-ahead FIFO model per column.
module tb_board_move_collector;
    import chess_move_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NCOLS*WORD_W-1:0] col_fifo_out = '0;
    logic [NCOLS-1:0]        col_fifo_empty;
    logic [NCOLS-1:0]        col_done;
    logic [NCOLS-1:0]        col_rden;
    logic [MOVE_W-1:0]       move_out;
    logic                    move_valid;
    logic                    move_ready;
    logic [CNT_W-1:0]        move_count;
    logic                    done;
`ifdef CAPTURE_COUNT_EN
    logic [CNT_W-1:0]        capture_count;
`endif

    always #5 clk = ~clk;

    board_move_collector dut (
        .clk            (clk),
        .reset          (reset),
        .col_fifo_out   (col_fifo_out),
        .col_fifo_empty (col_fifo_empty),
        .col_done       (col_done),
        .col_rden       (col_rden),
        .move_out       (move_out),
        .move_valid     (move_valid),
        .move_ready     (move_ready),
        .move_count     (move_count),
`ifdef CAPTURE_COUNT_EN
        .capture_count  (capture_count),
`endif
        .done           (done)
    );

    logic [WORD_W-1:0] mem [NCOLS][16];
    int                wp [NCOLS] = '{default: 0};
    int                rp [NCOLS] = '{default: 0};
    logic              flush = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < NCOLS; c++) begin
            if (flush) begin
                rp[c] <= wp[c];
            end else if (col_rden[c] && rp[c] != wp[c]) begin
                col_fifo_out[c*WORD_W +: WORD_W] <= mem[c][rp[c] % 16];
                rp[c] <= rp[c] + 1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCOLS; c++) begin
            col_fifo_empty[c] = (rp[c] == wp[c]);
        end
    end

    int tests = 0;
    int fails = 0;
    int rden_bad = 0;
    int rden_log [$];
    logic [MOVE_W-1:0] mv_log [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MOVE_W-1:0] mv(logic [5:0] fl, logic [5:0] fr,
                                             logic [5:0] to);
        return {1'b0, fl, fr, to};
    endfunction

    function automatic logic [WORD_W-1:0] all_inv();
        logic [WORD_W-1:0] w;
        for (int k = 0; k < SLOTS; k++) w[k*MOVE_W +: MOVE_W] = 19'h40000;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] full(int base);
        logic [WORD_W-1:0] w;
        for (int k = 0; k < SLOTS; k++)
            w[k*MOVE_W +: MOVE_W] = mv(6'(k), 6'(base + k), 6'(base + k + 1));
        return w;
    endfunction

    task automatic push(int c, logic [WORD_W-1:0] w);
        mem[c][wp[c] % 16] = w;
        wp[c] = wp[c] + 1;
    endtask

    // sample just after each negedge; valid&&ready here is accepted next edge
    task automatic run(int n);
        repeat (n) begin
            #1;
            if ($countones(col_rden) > 1) rden_bad++;
            for (int c = 0; c < NCOLS; c++) if (col_rden[c]) rden_log.push_back(c);
            if (move_valid && move_ready) mv_log.push_back(move_out);
            @(negedge clk);
        end
    endtask

    task automatic clear_logs();
        rden_log.delete();
        mv_log.delete();
    endtask

    task automatic wait_valid(string tag);
        int k = 0;
        while (!move_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(move_valid), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [WORD_W-1:0] w, wa, wb;
    logic [MOVE_W-1:0] m0, m1, m2;

    initial begin
        reset      = 1'b0;
        move_ready = 1'b1;
        col_done   = '0;
        repeat (2) @(negedge clk);
        chk("rst_rden", 32'(col_rden), 32'd0);
        chk("rst_valid", 32'(move_valid), 32'd0);
        chk("rst_out", 32'(move_out), 32'd0);
        chk("rst_count", 32'(move_count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // column 3: slots 0,2,5 valid
        m0 = mv(6'b000010, 6'd12, 6'd28);
        m1 = mv(6'b000001, 6'd8, 6'd16);
        m2 = mv(6'b100000, 6'd52, 6'd60);
        w = all_inv();
        w[0*MOVE_W +: MOVE_W] = m0;
        w[2*MOVE_W +: MOVE_W] = m1;
        w[5*MOVE_W +: MOVE_W] = m2;
        push(3, w);
        clear_logs();
        run(15);
        chk("t2_rden_pulses", 32'(rden_log.size()), 32'd1);
        if (rden_log.size() == 1) chk("t2_rden_col", 32'(rden_log[0]), 32'd3);
        chk("t2_moves", 32'(mv_log.size()), 32'd3);
        if (mv_log.size() == 3) begin
            chk("t2_mv0", 32'(mv_log[0]), 32'(m0));
            chk("t2_mv1", 32'(mv_log[1]), 32'(m1));
            chk("t2_mv2", 32'(mv_log[2]), 32'(m2));
        end
        chk("t2_count", 32'(move_count), 32'd3);
        chk("t2_idle_valid", 32'(move_valid), 32'd0);

        // move rr_ptr to 1 via a column-0 word using the last slot
        w = all_inv();
        w[7*MOVE_W +: MOVE_W] = mv(6'd0, 6'd1, 6'd2);
        push(0, w);
        clear_logs();
        run(12);
        chk("t3_pre_count", 32'(move_count), 32'd4);
        chk("t3_pre_move", 32'(mv_log.size() == 1 ? mv_log[0] : '0),
            32'(mv(6'd0, 6'd1, 6'd2)));

        wa = all_inv();
        wa[1*MOVE_W +: MOVE_W] = mv(6'b000001, 6'd3, 6'd4);
        wb = all_inv();
        wb[4*MOVE_W +: MOVE_W] = mv(6'b000100, 6'd5, 6'd6);
        push(0, wa);
        push(5, wb);
        clear_logs();
        run(25);
        chk("t3_rden_pulses", 32'(rden_log.size()), 32'd2);
        if (rden_log.size() == 2) begin
            chk("t3_first_col", 32'(rden_log[0]), 32'd5);
            chk("t3_second_col", 32'(rden_log[1]), 32'd0);
        end
        if (mv_log.size() == 2) begin
            chk("t3_mv0", 32'(mv_log[0]), 32'(mv(6'b000100, 6'd5, 6'd6)));
            chk("t3_mv1", 32'(mv_log[1]), 32'(mv(6'b000001, 6'd3, 6'd4)));
        end
        chk("t3_count", 32'(move_count), 32'd6);

        // backpressure on the first move of column 2
        m0 = mv(6'b010000, 6'd10, 6'd11);
        m1 = mv(6'b000001, 6'd20, 6'd21);
        w = all_inv();
        w[0*MOVE_W +: MOVE_W] = m0;
        w[3*MOVE_W +: MOVE_W] = m1;
        push(2, w);
        move_ready = 1'b0;
        wait_valid("t4_valid_seen");
        for (int i = 0; i < 4; i++) begin
            chk("t4_hold", {12'd0, move_valid, move_out}, {12'd0, 1'b1, m0});
            chk("t4_hold_count", 32'(move_count), 32'd6);
            @(negedge clk);
        end
        move_ready = 1'b1;
        @(negedge clk);
        chk("t4_count_once", 32'(move_count), 32'd7);
        chk("t4_next_move", 32'(move_out), 32'(m1));
        @(negedge clk);
        chk("t4_count_two", 32'(move_count), 32'd8);
        run(4);

        // reset while a move is pending
        w = all_inv();
        w[1*MOVE_W +: MOVE_W] = mv(6'd1, 6'd30, 6'd31);
        w[4*MOVE_W +: MOVE_W] = mv(6'd2, 6'd32, 6'd33);
        w[6*MOVE_W +: MOVE_W] = mv(6'd3, 6'd34, 6'd35);
        push(7, w);
        move_ready = 1'b0;
        wait_valid("t1_valid_seen");
        reset = 1'b0;
        @(negedge clk);
        chk("t1_rden", 32'(col_rden), 32'd0);
        chk("t1_valid", 32'(move_valid), 32'd0);
        chk("t1_count", 32'(move_count), 32'd0);
        chk("t1_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        move_ready = 1'b1;
        clear_logs();
        run(10);
        chk("t1_no_stale", 32'(mv_log.size()), 32'd0);
        chk("t1_no_read", 32'(rden_log.size()), 32'd0);
        chk("t1_count_after", 32'(move_count), 32'd0);

        // 20 moves then done
        push(1, full(0));
        push(4, full(10));
        w = all_inv();
        for (int k = 0; k < 4; k++)
            w[k*MOVE_W +: MOVE_W] = mv(6'd0, 6'(40 + k), 6'(50 + k));
        push(6, w);
        col_done = '1;
        clear_logs();
        begin
            int k = 0;
            while (!done && k < 100) begin
                run(1);
                k++;
            end
        end
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_count", 32'(move_count), 32'd20);
        chk("t5_moves", 32'(mv_log.size()), 32'd20);
        push(2, full(20));
        clear_logs();
        run(6);
        chk("t5_done_sticky", 32'(done), 32'd1);
        chk("t5_no_read", 32'(rden_log.size()), 32'd0);
        chk("t5_valid_low", 32'(move_valid), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;

        // counter saturation: 256 moves
        col_done = '0;
        do_reset();
        for (int c = 0; c < NCOLS; c++)
            for (int j = 0; j < 4; j++) push(c, full(c + j));
        clear_logs();
        run(420);
        chk("sat_moves", 32'(mv_log.size()), 32'd256);
        chk("sat_count", 32'(move_count), 32'd255);
        chk("sat_not_done", 32'(done), 32'd0);

        // eight valid slots, three captures
        do_reset();
        w = '0;
        for (int k = 0; k < SLOTS; k++)
            w[k*MOVE_W +: MOVE_W] = mv((k == 1 || k == 4 || k == 6) ?
                                       6'b000001 : 6'b000010,
                                       6'(k), 6'(k + 8));
        push(2, w);
        clear_logs();
        run(20);
        chk("t6_count", 32'(move_count), 32'd8);
`ifdef CAPTURE_COUNT_EN
        chk("t6_captures", 32'(capture_count), 32'd3);
`endif
        chk("rden_onehot", 32'(rden_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/board_move_collector.md
Name: board_move_collector

Overview:
- Sits directly downstream of the eight column units.
- Round-robin drains each column's 152-bit move FIFO words.
- Unpacks each word into eight 19-bit move slots, drops invalid slots, and presents one move per cycle on a valid/ready stream to the search/eval stage.
- Counts moves and raises done once every column is finished and drained.

Parameters:
- NCOLS, 8: number of column units serviced.
- MOVE_W, 19: move width, {7b flag, 6b from, 6b to}.
- SLOTS, 8: moves per column FIFO word; word width = SLOTS*MOVE_W = 152.
- CNT_W, 8: move counter width.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-low. Asserted when 0 and sampled on the rising clk edge.
- col_fifo_out, in, NCOLS*152: column c word at [152c+151:152c].
- col_fifo_empty, in, NCOLS: per-column FIFO empty flag.
- col_done, in, NCOLS: per-column done level.
- col_rden, out, NCOLS: per-column FIFO read enable, one-hot or zero.
- move_out, out, MOVE_W: current move.
- move_valid, out, 1: move_out is valid.
- move_ready, in, 1: consumer accepts the move.
- move_count, out, CNT_W: number of valid moves accepted so far.
- done, out, 1: all columns done, drained and emitted.

Behaviour:
- Reset (reset==0): outputs and state
  - col_rden=0, move_valid=0, move_out=0, move_count=0, done=0.
  - state=SCAN, rr_ptr=0, word register cleared.
  - Reset mid-operation discards any latched word and in-flight read.
- Slot layout: slot k = word[19k+18:19k].
  - Bit 18 = invalid; bits 17..12 = promote, pawn move, pawn 2sq, en passant, castle, capture; [11:6] = from; [5:0] = to.
- Column FIFO timing: q is valid the cycle after rden (non-show-ahead).
- FSM:
  - SCAN: search columns rr_ptr, rr_ptr+1 … (mod NCOLS) for the first with col_fifo_empty==0.
    - If found: assert col_rden[c] for exactly one cycle, set cur_col=c, go to WAIT.
    - If none is found, all col_done==1 and all empty: go to DONE.
  - WAIT: one cycle for FIFO data; go to CAPT.
  - CAPT: latch col_fifo_out[cur_col] into the word register; slot_ptr=0; go to EMIT.
  - EMIT: the next non-invalid slot at or after slot_ptr drives move_out with move_valid=1.
    - On move_valid&&move_ready: increment move_count and advance past that slot.
    - Invalid slots are skipped at zero cycle cost, combinationally, by a priority find.
    - When no valid slots remain: move_valid=0, rr_ptr=cur_col+1 (wraps 7→0), go to SCAN.
    - A word with all slots invalid emits nothing and returns to SCAN.
  - DONE: done=1, move_valid=0, col_rden=0. Sticky until reset.
- Handshake:
  - move_out and move_valid stay stable while move_valid && !move_ready.
  - move_valid never drops without acceptance except on reset.
- move_count saturates at 2^CNT_W-1 with no wrap.
- A column whose done rises while its FIFO is non-empty keeps being drained; done for the block waits for it.
- A column with col_done==0 and an empty FIFO blocks DONE indefinitely. No timeout.
- Only one column is read per word. col_rden is never asserted in WAIT, CAPT, EMIT or DONE.
- Throughput: 3 cycles of overhead per word plus one cycle per accepted move.

Optional Feature:
- Macro CAPTURE_COUNT_EN.
- Defined: adds output capture_count [CNT_W-1:0].
  - Increments on each accepted move with flag bit 12 (capture) set.
  - Reset to 0; saturating.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package chess_move_pkg holds:
  - MOVE_W, SLOTS, and the field bit positions: INV=18, PROMO=17, PAWN=16, PAWN2=15, EP=14, CASTLE=13, CAPT=12.
  - FROM/TO slice constants.
  - FSM state encoding: SCAN, WAIT, CAPT, EMIT, DONE.
- Sub-module move_unpacker: owns the word register, slot_ptr, the valid-slot priority find and the valid/ready output stage.
  - Interface: load, word_in, move_out, move_valid, move_ready, word_empty.
- The top level keeps the round-robin arbiter, the FSM and the counters.

Test Plan:
1. Reset held low for 2 cycles mid-EMIT → next cycle col_rden=0, move_valid=0, move_count=0, done=0; no stale move appears after release.
2. Column 3 holds one word with slots 0,2,5 valid (from=12,to=28 in slot 0), others invalid, and move_ready=1 → three moves emitted in slot order, move_count=3, col_rden[3] high for exactly 1 cycle.
3. Columns 0 and 5 each non-empty, rr_ptr=1 → column 5 is serviced before column 0; after column 5, column 0 is serviced (wrap).
4. move_ready held low 4 cycles on the first move → move_out and move_valid are stable for all 4 cycles; the count increments only once on acceptance.
5. All col_done=1, FIFOs empty after draining 20 moves → done=1 with move_count=20; done stays high after further col_fifo_empty toggles.
6. CAPTURE_COUNT_EN defined with 8 valid slots, 3 of which have bit 12 set → capture_count=3, move_count=8.
